// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder.sv
// One-bit full-adder cell: sum and carry out of a + b + cin.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one operand bit per clock
// through a single full-adder cell, carry held in a flip-flop between bits.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only in IDLE (busy=0) and is dropped, not
  // queued, while busy=1; done pulses for one cycle when result/cout/overflow
  // take their new values, and those hold until the next completed operation.
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic             last;
  logic             fa_sum, fa_cout;

  assign last = (cnt == LAST);
  assign busy = (state != IDLE);

  adder u_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= (op == OP_SUB) ? ~b : b;
            carry <= op;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          // On the MSB, the carry register holds the carry into the MSB.
          if (last) begin
            result   <= {fa_sum, res_sh[WIDTH-1:1]};
            cout     <= fa_cout;
            overflow <= carry ^ fa_cout;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  // Expected entries packed as {overflow, cout, result}.
  logic [W+1:0] exp_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, sv, ur;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == 1'b0) begin
      ur = (ux + uy) % 256;
      co = (ux + uy) > 255;
      sv = sx + sy;
    end else begin
      ur = (ux - uy + 256) % 256;
      co = (ux >= uy);
      sv = sx - sy;
    end
    ov = (sv > 127) || (sv < -128);
    return {ov, co, ur[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency and results.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] e;
    int cyc;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(model(o, x, y));
    // Scramble operands after acceptance; they must not matter.
    a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 9) begin
      n_err++; $display("FAIL latency op=%b a=%h b=%h: got %0d cycles want 9", o, x, y, cyc);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({overflow, cout, result} !== e) begin
      n_err++;
      $display("FAIL result op=%b a=%h b=%h: got ov=%b co=%b r=%h want ov=%b co=%b r=%h",
               o, x, y, overflow, cout, result, e[W+1], e[W], e[W-1:0]);
    end
    tick();
    n_cmp++;
    if ({busy, done, overflow, cout, result} !== {2'b00, e}) begin
      n_err++;
      $display("FAIL hold_after_done: got busy=%b done=%b ov=%b co=%b r=%h want busy=0 done=0 ov=%b co=%b r=%h",
               busy, done, overflow, cout, result, e[W+1], e[W], e[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b r=%h co=%b ov=%b want all 0",
               busy, done, result, cout, overflow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    do_op(1'b0, 8'h25, 8'h1A);
    do_op(1'b0, 8'h7F, 8'h01);
    do_op(1'b0, 8'hFF, 8'h01);
    do_op(1'b1, 8'h10, 8'h20);
    do_op(1'b1, 8'h80, 8'h01);
    do_op(1'b1, 8'h00, 8'h80);
    do_op(1'b0, 8'h80, 8'h80);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_ignored_start();
    logic [W+1:0] e;
    int n_done;
    op = 1'b0; a = 8'h01; b = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    e = model(1'b0, 8'h01, 8'h02);
    n_done = 0;
    for (int k = 1; k < 30; k++) begin
      if (k == 4) begin
        start = 1'b1; op = 1'b1; a = 8'h55; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        n_done++;
        n_cmp++;
        if ({overflow, cout, result} !== e) begin
          n_err++;
          $display("FAIL ignored_start_result: got ov=%b co=%b r=%h want ov=%b co=%b r=%h",
                   overflow, cout, result, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_err++; $display("FAIL ignored_start_count: got %0d done pulses want 1", n_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    op = 1'b0; a = 8'h33; b = 8'h44; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: got busy=%b done=%b r=%h co=%b ov=%b want all 0",
               busy, done, result, cout, overflow);
    end
    n_done = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0 || result !== 8'h00) begin
      n_err++; $display("FAIL reset_abort: got %0d done pulses r=%h want 0 pulses r=00", n_done, result);
    end
    do_op(1'b1, 8'h05, 8'h09);
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e;
    logic exp_done, exp_busy;
    op = 1'($urandom); a = W'($urandom); b = W'($urandom); start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 0 || k == 10 || k == 20) begin
        exp_q.push_back(model(op, a, b));
        op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        if (k == 20) start = 1'b0;
      end
      exp_done = (k % 10 == 8) && (k < 30);
      exp_busy = !((k == 9) || (k == 19) || (k >= 29));
      n_cmp++;
      if (done !== exp_done || busy !== exp_busy) begin
        n_err++;
        $display("FAIL b2b_timing k=%0d: got done=%b busy=%b want done=%b busy=%b",
                 k, done, busy, exp_done, exp_busy);
      end
      if (done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({overflow, cout, result} !== e) begin
          n_err++;
          $display("FAIL b2b_result k=%0d: got ov=%b co=%b r=%h want ov=%b co=%b r=%h",
                   k, overflow, cout, result, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL b2b_leftover: got %0d pending results want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
